// File: rtl/mips_pkg.sv
// Shared definitions for the tinycpu decode/execute stage: encodings, FSM states,
// register names and the instruction decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] ZERO = 5'd0,  AT = 5'd1,  V0 = 5'd2,  V1 = 5'd3;
  localparam logic [4:0] A0   = 5'd4,  A1 = 5'd5,  A2 = 5'd6,  A3 = 5'd7;
  localparam logic [4:0] T0   = 5'd8,  T1 = 5'd9,  T2 = 5'd10, T3 = 5'd11;
  localparam logic [4:0] T4   = 5'd12, T5 = 5'd13, T6 = 5'd14, T7 = 5'd15;
  localparam logic [4:0] S0   = 5'd16, S1 = 5'd17, S2 = 5'd18, S3 = 5'd19;
  localparam logic [4:0] S4   = 5'd20, S5 = 5'd21, S6 = 5'd22, S7 = 5'd23;
  localparam logic [4:0] T8   = 5'd24, T9 = 5'd25, K0 = 5'd26, K1 = 5'd27;
  localparam logic [4:0] GP   = 5'd28, SP = 5'd29, FP = 5'd30, RA = 5'd31;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    EXEC     = 3'd2,
    WB       = 3'd3,
    WAIT_ACK = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU,
    ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_ILL
  } alu_op_t;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       use_imm;
    logic       imm_sext;
    logic [4:0] dest;
  } decode_t;

  // addi maps to ALU_ADD and addiu to ALU_ADDU so that only the trapping forms share an op.
  function automatic decode_t mips_decode(input logic [5:0] opcode, input logic [5:0] funct,
                                          input logic [4:0] rt, input logic [4:0] rd);
    decode_t d;
    d.alu_op   = ALU_ILL;
    d.use_imm  = 1'b1;
    d.imm_sext = 1'b0;
    d.dest     = rt;
    case (opcode)
      OP_RTYPE: begin
        d.use_imm = 1'b0;
        d.dest    = rd;
        case (funct)
          FN_ADD:  d.alu_op = ALU_ADD;
          FN_ADDU: d.alu_op = ALU_ADDU;
          FN_SUB:  d.alu_op = ALU_SUB;
          FN_SUBU: d.alu_op = ALU_SUBU;
          FN_AND:  d.alu_op = ALU_AND;
          FN_OR:   d.alu_op = ALU_OR;
          FN_XOR:  d.alu_op = ALU_XOR;
          FN_NOR:  d.alu_op = ALU_NOR;
          FN_SLT:  d.alu_op = ALU_SLT;
          FN_SLTU: d.alu_op = ALU_SLTU;
          default: d.alu_op = ALU_ILL;
        endcase
      end
      OP_ADDI:  begin d.alu_op = ALU_ADD;  d.imm_sext = 1'b1; end
      OP_ADDIU: begin d.alu_op = ALU_ADDU; d.imm_sext = 1'b1; end
      OP_SLTI:  begin d.alu_op = ALU_SLT;  d.imm_sext = 1'b1; end
      OP_ANDI:  d.alu_op = ALU_AND;
      OP_ORI:   d.alu_op = ALU_OR;
      OP_XORI:  d.alu_op = ALU_XOR;
      default:  d.alu_op = ALU_ILL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// NUM_REGS x DATA_W register file: two combinational reads, one synchronous write.
// Register 0 and indices >= NUM_REGS read as zero and ignore writes.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [4:0]        rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [4:0]        wa_addr,
  input  logic [DATA_W-1:0] wd
);
  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];

  function automatic logic live(input logic [4:0] a);
    return (a != ZERO) && (int'(a) < NUM_REGS);
  endfunction

  assign ra_data = live(ra_addr) ? regs[ra_addr[AW-1:0]] : '0;
  assign rb_data = live(rb_addr) ? regs[rb_addr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && live(wa_addr)) begin
      regs[wa_addr[AW-1:0]] <= wd;
    end
  end

endmodule

// File: rtl/mips_decode_exec.sv
// Single-issue decode/execute stage with DIR/ack_prev input and DOR/ack_from_next output handshakes.
// Build option OVERFLOW_TRAP_EN: signed overflow on add/addi/sub pulses trap and suppresses writeback.
//
// state    | meaning
// IDLE     | wait for DIR; accept a legal instruction or reject it with illegal
// FETCH    | read rs/rt into S/T
// EXEC     | compute result D
// WB       | write D back and raise DOR, or pulse trap and drop the result
// WAIT_ACK | hold DOR/data_out until ack_from_next
module mips_decode_exec
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DIR,
  input  logic [31:0]       data_in,
  output logic              ack_prev,
  output logic              DOR,
  input  logic              ack_from_next,
  output logic [DATA_W-1:0] data_out,
  output logic              illegal,
  output logic              trap,
  output logic              busy
);
  state_t            state_q, state_d;
  decode_t           dec_in, dec_q;
  logic [4:0]        rs_q, rt_q;
  logic [15:0]       imm_q;
  logic [DATA_W-1:0] s_q, t_q, d_q, rd_s, rd_t;
  logic [DATA_W-1:0] imm_ext, op_b, sum, diff, alu_y;
  logic              in_legal, accept, trap_hit, wb_en;
  logic              ack_prev_d, illegal_d, dor_d, trap_d;
  logic [DATA_W-1:0] data_out_d;

  assign dec_in   = mips_decode(data_in[31:26], data_in[5:0], data_in[20:16], data_in[15:11]);
  assign in_legal = (dec_in.alu_op != ALU_ILL);
  assign accept   = (state_q == IDLE) && DIR && in_legal;
  assign busy     = (state_q != IDLE);

  mips_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (rs_q),
    .ra_data (rd_s),
    .rb_addr (rt_q),
    .rb_data (rd_t),
    .we      (wb_en),
    .wa_addr (dec_q.dest),
    .wd      (d_q)
  );

  always_comb begin
    imm_ext = dec_q.imm_sext ? DATA_W'($signed(imm_q)) : DATA_W'(imm_q);
    op_b    = dec_q.use_imm ? imm_ext : t_q;
    sum     = s_q + op_b;
    diff    = s_q - op_b;
    alu_y   = '0;
    case (dec_q.alu_op)
      ALU_ADD, ALU_ADDU: alu_y = sum;
      ALU_SUB, ALU_SUBU: alu_y = diff;
      ALU_AND:           alu_y = s_q & op_b;
      ALU_OR:            alu_y = s_q | op_b;
      ALU_XOR:           alu_y = s_q ^ op_b;
      ALU_NOR:           alu_y = ~(s_q | op_b);
      ALU_SLT:           alu_y = DATA_W'($signed(s_q) < $signed(op_b));
      ALU_SLTU:          alu_y = DATA_W'(s_q < op_b);
      default:           alu_y = '0;
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  logic ovf_q, ovf_d;

  // Overflow: operands agree in sign (add) or differ (sub) and the result sign flips.
  always_comb begin
    ovf_d = 1'b0;
    case (dec_q.alu_op)
      ALU_ADD: ovf_d = (s_q[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != s_q[DATA_W-1]);
      ALU_SUB: ovf_d = (s_q[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != s_q[DATA_W-1]);
      default: ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                 ovf_q <= 1'b0;
    else if (state_q == EXEC)  ovf_q <= ovf_d;
  end

  assign trap_hit = ovf_q;
`else
  assign trap_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ack_prev <= 1'b0;
      illegal  <= 1'b0;
      DOR      <= 1'b0;
      trap     <= 1'b0;
      data_out <= '0;
    end else begin
      state_q  <= state_d;
      ack_prev <= ack_prev_d;
      illegal  <= illegal_d;
      DOR      <= dor_d;
      trap     <= trap_d;
      data_out <= data_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = FETCH;
      FETCH:    state_d = EXEC;
      EXEC:     state_d = WB;
      WB:       state_d = trap_hit ? IDLE : WAIT_ACK;
      WAIT_ACK: if (ack_from_next) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_prev_d = (state_q == IDLE) && DIR;
    illegal_d  = ack_prev_d && !in_legal;
    trap_d     = (state_q == WB) && trap_hit;
    wb_en      = (state_q == WB) && !trap_hit;
    dor_d      = DOR;
    data_out_d = data_out;
    if (wb_en) begin
      dor_d      = 1'b1;
      data_out_d = d_q;
    end else if ((state_q == WAIT_ACK) && ack_from_next) begin
      dor_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q <= '0;
      t_q <= '0;
      d_q <= '0;
    end else begin
      if (state_q == FETCH) begin
        s_q <= rd_s;
        t_q <= rd_t;
      end
      if (state_q == EXEC) d_q <= alu_y;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      dec_q <= dec_in;
      rs_q  <= data_in[25:21];
      rt_q  <= data_in[20:16];
      imm_q <= data_in[15:0];
    end
  end

endmodule

// File: tb/tb_mips_decode_exec.sv
// Directed bench for mips_decode_exec: a 32-bit/32-register instance driven from a vector
// table, and a 16-bit/16-register instance for overflow and out-of-range register cases.
module tb_mips_decode_exec;
  localparam int K_OK = 0, K_ILL = 1, K_TRAP = 2;
`ifdef OVERFLOW_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    int          kind;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic        ack, dor, ill, trp, bsy;
    logic [31:0] dout;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  dir, ackn;
  logic [31:0] din_a, din_b;
  logic        ack_a, dor_a, ill_a, trp_a, bsy_a;
  logic        ack_b, dor_b, ill_b, trp_b, bsy_b;
  logic [31:0] dout_a;
  logic [15:0] dout_b;
  int          checks = 0, failures = 0;
  vec_t        tbl [24];

  always #5 clk = ~clk;

  mips_decode_exec #(.DATA_W(32), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .DIR(dir[0]), .data_in(din_a), .ack_prev(ack_a), .DOR(dor_a),
    .ack_from_next(ackn[0]), .data_out(dout_a), .illegal(ill_a), .trap(trp_a), .busy(bsy_a)
  );

  mips_decode_exec #(.DATA_W(16), .NUM_REGS(16)) dut16 (
    .clk(clk), .reset(reset), .DIR(dir[1]), .data_in(din_b), .ack_prev(ack_b), .DOR(dor_b),
    .ack_from_next(ackn[1]), .data_out(dout_b), .illegal(ill_b), .trap(trp_b), .busy(bsy_b)
  );

  function automatic obs_t snap(input int sel);
    obs_t o;
    if (sel == 1) begin
      o.ack = ack_b; o.dor = dor_b; o.ill = ill_b; o.trp = trp_b; o.bsy = bsy_b;
      o.dout = {16'h0, dout_b};
    end else begin
      o.ack = ack_a; o.dor = dor_a; o.ill = ill_a; o.trp = trp_a; o.bsy = bsy_a;
      o.dout = dout_a;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one instruction and checks the handshake edge by edge (E0..E4).
  task automatic run(input int sel, input logic [31:0] instr, input int kind,
                     input logic [31:0] exp, input string nm);
    obs_t o;
    if (sel == 1) din_b = instr; else din_a = instr;
    dir[sel] = 1'b1;
    tick();
    dir[sel] = 1'b0;
    o = snap(sel);
    chk({nm, ".ack_e0"}, o.ack, 1);
    chk({nm, ".illegal_e0"}, o.ill, (kind == K_ILL));
    if (kind == K_ILL) begin
      chk({nm, ".busy_ill"}, o.bsy, 0);
      tick();
      o = snap(sel);
      chk({nm, ".ack_e1"}, o.ack, 0);
      chk({nm, ".illegal_e1"}, o.ill, 0);
      chk({nm, ".dor_ill"}, o.dor, 0);
      chk({nm, ".busy_ill_e1"}, o.bsy, 0);
      return;
    end
    chk({nm, ".busy_e0"}, o.bsy, 1);
    tick();
    o = snap(sel);
    chk({nm, ".ack_e1"}, o.ack, 0);
    tick();
    o = snap(sel);
    chk({nm, ".dor_e2"}, o.dor, 0);
    tick();
    o = snap(sel);
    if (kind == K_TRAP) begin
      chk({nm, ".trap_e3"}, o.trp, 1);
      chk({nm, ".dor_trap"}, o.dor, 0);
      chk({nm, ".busy_trap"}, o.bsy, 0);
      tick();
      o = snap(sel);
      chk({nm, ".trap_e4"}, o.trp, 0);
      chk({nm, ".dor_trap_e4"}, o.dor, 0);
      return;
    end
    chk({nm, ".dor_e3"}, o.dor, 1);
    chk({nm, ".trap_e3"}, o.trp, 0);
    chk({nm, ".data"}, o.dout, exp);
    ackn[sel] = 1'b1;
    tick();
    ackn[sel] = 1'b0;
    o = snap(sel);
    chk({nm, ".dor_e4"}, o.dor, 0);
    chk({nm, ".busy_e4"}, o.bsy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    tbl[0]  = '{32'h20080005, K_OK,  32'h00000005};  // addi t0,zero,5
    tbl[1]  = '{32'h20090007, K_OK,  32'h00000007};  // addi t1,zero,7
    tbl[2]  = '{32'h01095020, K_OK,  32'h0000000C};  // add t2,t0,t1
    tbl[3]  = '{32'h0128582A, K_OK,  32'h00000000};  // slt t3,t1,t0
    tbl[4]  = '{32'h20000009, K_OK,  32'h00000009};  // addi zero,zero,9
    tbl[5]  = '{32'h00005820, K_OK,  32'h00000000};  // add t3,zero,zero
    tbl[6]  = '{32'h01096022, K_OK,  32'hFFFFFFFE};  // sub t4,t0,t1
    tbl[7]  = '{32'h010C682B, K_OK,  32'h00000001};  // sltu t5,t0,t4
    tbl[8]  = '{32'h010C682A, K_OK,  32'h00000000};  // slt t5,t0,t4
    tbl[9]  = '{32'h298EFFFF, K_OK,  32'h00000001};  // slti t6,t4,-1
    tbl[10] = '{32'h318FFF00, K_OK,  32'h0000FF00};  // andi t7,t4,0xFF00
    tbl[11] = '{32'h3510F0F0, K_OK,  32'h0000F0F5};  // ori s0,t0,0xF0F0
    tbl[12] = '{32'h399100FF, K_OK,  32'hFFFFFF01};  // xori s1,t4,0xFF
    tbl[13] = '{32'h01009027, K_OK,  32'hFFFFFFFA};  // nor s2,t0,zero
    tbl[14] = '{32'h01889824, K_OK,  32'h00000004};  // and s3,t4,t0
    tbl[15] = '{32'h0109A025, K_OK,  32'h00000007};  // or s4,t0,t1
    tbl[16] = '{32'h0109A826, K_OK,  32'h00000002};  // xor s5,t0,t1
    tbl[17] = '{32'h0008B023, K_OK,  32'hFFFFFFFB};  // subu s6,zero,t0
    tbl[18] = '{32'h018CB821, K_OK,  32'hFFFFFFFC};  // addu s7,t4,t4
    tbl[19] = '{32'h2518FFFF, K_OK,  32'h00000004};  // addiu t8,t0,-1
    tbl[20] = '{32'h0000003F, K_ILL, 32'h00000000};  // R-type funct 0x3F
    tbl[21] = '{32'hFC000000, K_ILL, 32'h00000000};  // opcode 0x3F
    tbl[22] = '{32'h0109503F, K_ILL, 32'h00000000};  // illegal aimed at t2
    tbl[23] = '{32'h0140C825, K_OK,  32'h0000000C};  // or t9,t2,zero: t2 untouched

    reset = 1'b1; dir = 2'b00; ackn = 2'b00; din_a = '0; din_b = '0;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      o = snap(s);
      chk($sformatf("reset%0d.dor", s), o.dor, 0);
      chk($sformatf("reset%0d.ack", s), o.ack, 0);
      chk($sformatf("reset%0d.busy", s), o.bsy, 0);
      chk($sformatf("reset%0d.data", s), o.dout, 0);
    end
    reset = 1'b0;

    for (int i = 0; i < 24; i++)
      run(0, tbl[i].instr, tbl[i].kind, tbl[i].exp, $sformatf("vec%0d", i));

    run(1, 32'h34087FFF, K_OK, 32'h00007FFF, "w16_ori");
    run(1, 32'h21090001, TRAP_ON ? K_TRAP : K_OK, 32'h00008000, "w16_addi_ovf");
    run(1, 32'h01205020, K_OK, TRAP_ON ? 32'h0 : 32'h00008000, "w16_read_t1");
    run(1, 32'h250B0001, K_OK, 32'h00008000, "w16_addiu");
    run(1, 32'h20140003, K_OK, 32'h00000003, "w16_oor_write");
    run(1, 32'h02805020, K_OK, 32'h00000000, "w16_oor_read");

    // Downstream stalls with DIR held high; result must hold and nothing new is accepted.
    din_a = 32'h2008002A;
    dir[0] = 1'b1;
    tick();
    chk("stall.ack_e0", ack_a, 1);
    din_a = 32'h20090063;
    tick();
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("stall%0d.dor", c), dor_a, 1);
      chk($sformatf("stall%0d.data", c), dout_a, 32'h0000002A);
      chk($sformatf("stall%0d.ack", c), ack_a, 0);
    end
    reset = 1'b1;
    tick();
    chk("mid_reset.dor", dor_a, 0);
    chk("mid_reset.busy", bsy_a, 0);
    chk("mid_reset.data", dout_a, 0);
    reset = 1'b0;
    dir[0] = 1'b0;
    tick();
    run(0, 32'h01005020, K_OK, 32'h00000000, "post_reset_t0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
